// File: rtl/eg_link_pkg.sv
// Shared definitions for the EG host link: command codes, FSM states and error flag positions.
package eg_link_pkg;

  typedef enum logic [7:0] {
    CMD_LOAD   = 8'h00,
    CMD_RUN    = 8'h01,
    CMD_DUMP   = 8'h02,
    CMD_CLRERR = 8'h03
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_DUMP_LEN,
    ST_DUMP_FETCH,
    ST_DUMP_DATA
  } state_e;

  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_TIMEOUT  = 1;
  localparam int ERR_BAD_CMD  = 2;
  localparam int ERR_BUSY_CMD = 3;

  // Number of bytes the host uses to carry a LEN_W-bit length field.
  function automatic int len_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/eg_host_link_if.sv
// Byte-level UART side of the host link: receive strobe/data and transmit start/busy handshake.
interface eg_host_link_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (output rx_data, output rx_valid, output tx_busy,
                  input  tx_data, input  tx_start);
  modport slave  (input  rx_data, input  rx_valid, input  tx_busy,
                  output tx_data, output tx_start);
endinterface

// File: rtl/eg_link_mem.sv
// DEPTH x 8 frame buffer: one write port, two independent registered read ports (core and dump).
module eg_link_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [7:0]        a_data,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [7:0]        b_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array and its read registers carry no reset so the buffer maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    a_data <= mem[a_addr];
    b_data <= mem[b_addr];
  end

endmodule

// File: rtl/eg_host_link.sv
// Host command parser and dump transmitter sitting between the UART and the compressor core.
module eg_host_link
  import eg_link_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  eg_host_link_if.slave     link,
  output logic              run_start,
  input  logic              run_busy,
  input  logic [ADDR_W-1:0] core_rd_addr,
  output logic [7:0]        core_rd_data,
  output logic [LEN_W-1:0]  buf_len,
  output logic              busy,
  output logic [3:0]        err
);

  localparam int LEN_BYTES = len_bytes(LEN_W);
  localparam int LB_W      = 8 * LEN_BYTES;
  localparam int K_W       = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(LEN_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]      DEPTH_U  = DEPTH;

  state_e             state, state_n;
  logic [K_W-1:0]     k, k_n;
  logic [LB_W-1:0]    len_acc, len_acc_n;
  logic [LEN_W-1:0]   frame_len, frame_len_n;
  logic [LEN_W-1:0]   store_len, store_len_n;
  logic [LEN_W-1:0]   rcv_cnt, rcv_cnt_n;
  logic [LEN_W-1:0]   rd_ptr, rd_ptr_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_n;
  logic [LEN_W-1:0]   buf_len_n;
  logic [3:0]         err_n, err_set;
  logic               err_clr;
  logic               tx_start_q, tx_start_n;
  logic [7:0]         tx_data_q, tx_data_n;
  logic               run_start_n;

  logic [LB_W-1:0]    len_asm, len_sh;
  logic [LEN_W-1:0]   len_val;
  logic               len_over, can_send;
  logic               mem_we;
  logic [7:0]         dump_q;

  eg_link_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (rcv_cnt[ADDR_W-1:0]),
    .wdata  (link.rx_data),
    .a_addr (core_rd_addr),
    .a_data (core_rd_data),
    .b_addr (rd_ptr[ADDR_W-1:0]),
    .b_data (dump_q)
  );

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n     = state;
    k_n         = k;
    len_acc_n   = len_acc;
    frame_len_n = frame_len;
    store_len_n = store_len;
    rcv_cnt_n   = rcv_cnt;
    rd_ptr_n    = rd_ptr;
    tmo_n       = '0;
    buf_len_n   = buf_len;
    err_set     = '0;
    err_clr     = 1'b0;
    tx_start_n  = 1'b0;
    tx_data_n   = tx_data_q;
    run_start_n = 1'b0;
    mem_we      = 1'b0;

    len_asm  = len_acc | (LB_W'(link.rx_data) << (8 * k));
    len_val  = len_asm[LEN_W-1:0];
    len_over = 32'(len_val) > DEPTH_U;
    len_sh   = LB_W'(buf_len) >> (8 * k);
    // uart_tx only raises busy the cycle after a start, so never start twice in a row.
    can_send = !link.tx_busy && !tx_start_q;

    case (state)
      ST_IDLE: begin
        if (link.rx_valid) begin
          case (link.rx_data)
            CMD_LOAD: begin
              state_n   = ST_LEN;
              buf_len_n = '0;
              k_n       = '0;
              len_acc_n = '0;
            end
            CMD_RUN: begin
              if (run_busy) err_set[ERR_BUSY_CMD] = 1'b1;
              else          run_start_n = 1'b1;
            end
            CMD_DUMP: begin
              state_n  = ST_DUMP_LEN;
              k_n      = '0;
              rd_ptr_n = '0;
            end
            CMD_CLRERR: err_clr = 1'b1;
            default:    err_set[ERR_BAD_CMD] = 1'b1;
          endcase
        end
      end

      ST_LEN, ST_DATA: begin
        if (link.rx_valid) begin
          if (state == ST_LEN) begin
            len_acc_n = len_asm;
            k_n       = k + 1'b1;
            if (k == K_LAST) begin
              if (len_val == '0) begin
                state_n = ST_IDLE;
              end else begin
                state_n     = ST_DATA;
                rcv_cnt_n   = '0;
                frame_len_n = len_val;
                store_len_n = len_over ? LEN_W'(DEPTH_U) : len_val;
                err_set[ERR_OVERFLOW] = len_over;
              end
            end
          end else begin
            // Bytes beyond the buffer are consumed but never written; the pointer does not wrap.
            mem_we    = 32'(rcv_cnt) < DEPTH_U;
            rcv_cnt_n = rcv_cnt + 1'b1;
            if ((rcv_cnt + LEN_W'(1)) == frame_len) begin
              state_n   = ST_IDLE;
              buf_len_n = store_len;
            end
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_n   = ST_IDLE;
          buf_len_n = '0;
          err_set[ERR_TIMEOUT] = 1'b1;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end

      ST_DUMP_LEN: begin
        if (can_send) begin
          tx_start_n = 1'b1;
          tx_data_n  = len_sh[7:0];
          k_n        = k + 1'b1;
          if (k == K_LAST) state_n = (buf_len == '0) ? ST_IDLE : ST_DUMP_FETCH;
        end
      end

      // One cycle for the registered dump read port to present mem[rd_ptr].
      ST_DUMP_FETCH: state_n = ST_DUMP_DATA;

      ST_DUMP_DATA: begin
        if (can_send) begin
          tx_start_n = 1'b1;
          tx_data_n  = dump_q;
          rd_ptr_n   = rd_ptr + 1'b1;
          state_n    = ((rd_ptr + LEN_W'(1)) == buf_len) ? ST_IDLE : ST_DUMP_FETCH;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    err_n = err_clr ? 4'b0 : (err | err_set);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      len_acc    <= '0;
      frame_len  <= '0;
      store_len  <= '0;
      rcv_cnt    <= '0;
      rd_ptr     <= '0;
      tmo_cnt    <= '0;
      buf_len    <= '0;
      err        <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      run_start  <= 1'b0;
    end else begin
      state      <= state_n;
      k          <= k_n;
      len_acc    <= len_acc_n;
      frame_len  <= frame_len_n;
      store_len  <= store_len_n;
      rcv_cnt    <= rcv_cnt_n;
      rd_ptr     <= rd_ptr_n;
      tmo_cnt    <= tmo_n;
      buf_len    <= buf_len_n;
      err        <= err_n;
      tx_start_q <= tx_start_n;
      tx_data_q  <= tx_data_n;
      run_start  <= run_start_n;
    end
  end

  assign busy          = (state != ST_IDLE);
  assign link.tx_start = tx_start_q;
  assign link.tx_data  = tx_data_q;

endmodule

// File: doc/eg_host_link.md
Name: eg_host_link

Overview:
- Parametrised successor to the single-command UART loader in the EG coding top level.
- Parses the host byte stream (command, length, payload) into an on-chip buffer and triggers the compressor core.
- Streams the buffer back to the host.
- Sits between uart_rx/uart_tx and the compression core; adds overflow and timeout handling, run and dump commands, and sticky error flags.

Parameters:
- DEPTH, 256, buffer size in bytes (power of two).
- ADDR_W, 8, log2(DEPTH).
- LEN_W, 16, width of the length field sent by the host; byte count = ceil(LEN_W/8), little endian.
- TIMEOUT_CYC, 1000000, idle clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  one-cycle strobe to uart_tx
- tx_busy  in  1  uart_tx busy
- run_start  out  1  one-cycle pulse to the core
- run_busy  in  1  core busy
- core_rd_addr  in  ADDR_W  core read address
- core_rd_data  out  8  buffer byte, registered, 1-cycle latency
- buf_len  out  LEN_W  stored byte count
- busy  out  1  high in any state other than IDLE
- err  out  4  sticky flags: {busy_cmd, bad_cmd, timeout, overflow}

Behaviour:
- Reset: state IDLE. tx_start, run_start, busy, err, buf_len and tx_data all 0. Buffer contents are undefined.
- Commands, accepted only in IDLE:
  - 0 LOAD: enter LEN; buf_len <= 0; byte index k <= 0.
  - 1 RUN: if !run_busy, pulse run_start the next cycle; otherwise set err[3]. Stay in IDLE.
  - 2 DUMP: enter DUMP.
  - 3 CLRERR: err <= 0.
  - Any other value: set err[2].
- LEN: collect LEN_W/8 length bytes, little endian; k counts them.
  - Length L == 0: return to IDLE, buf_len = 0.
  - L > DEPTH: set err[0]; store the first DEPTH bytes, consume and discard the remainder; buf_len = DEPTH.
  - Otherwise enter DATA.
- DATA: on rx_valid, write mem[ptr] and increment ptr. The frame completes on the cycle of the L-th byte's strobe; buf_len <= min(L, DEPTH) and state returns to IDLE on the next cycle.
  - Write pointer wraps never; writes are suppressed once ptr reaches DEPTH.
- Timeout: a counter is cleared on every rx_valid in LEN or DATA and otherwise increments. When it reaches TIMEOUT_CYC, set err[1], set buf_len <= 0, and return to IDLE. The partial data is discarded.
- DUMP: transmit buf_len as LEN_W/8 bytes (LSB first), then mem[0..buf_len-1], then return to IDLE.
  - tx_start is issued only when tx_busy == 0 and tx_start was not asserted in the previous cycle, because uart_tx raises busy one cycle after start.
  - tx_data is held stable from tx_start until the next tx_start.
  - The buffer read for dump uses a separate registered read port; its 1-cycle latency is absorbed by a FETCH substate.
  - buf_len == 0: send the length bytes only.
- rx_valid during DUMP: the byte is dropped and no flag is set.
- Memory: one write port (parser) and two independent registered read ports (core, dump). A core read during LOAD returns whatever is in memory; no hazard protection is provided.
- Reset mid-frame or mid-dump: immediate return to the reset state; the transmit byte already in flight in uart_tx completes.
- Simultaneous rx_valid and timeout expiry: the byte wins and the counter clears.
- Err flags set and clear in the same cycle (CLRERR): clear wins.

Decomposition:
- Package eg_link_pkg: command codes (CMD_LOAD=0, CMD_RUN=1, CMD_DUMP=2, CMD_CLRERR=3), state enum, err bit indices.
- Sub-module eg_link_mem: DEPTH x 8 buffer with 1 write and 2 registered read ports.
- The parser/transmit FSM and the timeout counter stay in eg_host_link.

Test Plan:
- Load basic: send 00, 04 00, AA BB CC DD -> buf_len = 4, mem[0..3] = AA BB CC DD, busy drops within 1 cycle of the last byte, err = 0.
- Overflow: send 00, 02 01 (L = 258), then 258 bytes of 0..257 mod 256 -> buf_len = 256, mem[255] = FF, err[0] = 1, state IDLE after the 258th byte.
- Timeout: with TIMEOUT_CYC = 100, send 00, 03 00, 11, then silence -> at 100 idle cycles err[1] = 1, buf_len = 0, busy = 0; the next 00 frame loads normally.
- Dump with back-pressure: after the load-basic frame, send 02 with tx_busy held high for 10 cycles after each start -> tx_data sequence 04 00 AA BB CC DD, exactly 6 tx_start pulses, none while tx_busy is high.
- Run and errors: send 01 with run_busy = 0 -> one run_start pulse. Send 01 with run_busy = 1 -> err[3] = 1. Send 07 -> err[2] = 1. Send 03 -> err = 0.
- Reset mid-load: assert rst after 2 of 4 data bytes -> all outputs 0 on the next cycle; a subsequent full frame loads correctly.
